msrv32_wb_load_unit: RTL

- Write-back stage driving the register-file write port: rd address, rd data and write enable.
- Registers execute-stage results and selects the write-back source: ALU, load, CSR or PC+4.
- Runs a load-wait FSM against the data-memory read handshake and aligns/extends load data.
- Stalls the pipeline while a load is outstanding.

---
 rtl/msrv32_pkg.sv | 19 +
 rtl/msrv32_load_align.sv | 39 +++
 rtl/msrv32_wb_load_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared encodings for the write-back stage: source select, load size and
// the load-wait state machine.
package msrv32_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_CSR  = 2'b10;
  localparam logic [1:0] WB_PC4  = 2'b11;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/msrv32_load_align.sv
// Load data formatting: picks the byte/half lane addressed by the load offset
// and sign- or zero-extends it to the full datapath width.
module msrv32_load_align
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  output logic [XLEN-1:0] result
);

  function automatic logic [XLEN-1:0] extend_byte(input logic [7:0] b, input logic uns);
    return {{(XLEN-8){~uns & b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] extend_half(input logic [15:0] h, input logic uns);
    return {{(XLEN-16){~uns & h[15]}}, h};
  endfunction

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = data[{offset, 3'b000} +: 8];
  assign half_lane = offset[1] ? data[31:16] : data[15:0];

  // Size 2'b11 has no defined meaning and falls through to a full word.
  always_comb begin
    result = data;
    case (size)
      LS_BYTE: result = extend_byte(byte_lane, load_unsigned);
      LS_HALF: result = extend_half(half_lane, load_unsigned);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/msrv32_wb_load_unit.sv
// Write-back stage: registers execute results onto the register-file write
// port and holds the pipeline while a data-memory load is outstanding.
module msrv32_wb_load_unit
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            valid_in,
  input  logic            rf_wr_en_in,
  input  logic [RA_W-1:0] rd_addr_in,
  input  logic [1:0]      wb_src_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] csr_data_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  input  logic [1:0]      load_size_in,
  input  logic            load_unsigned_in,
  input  logic [XLEN-1:0] dmem_rdata_in,
  input  logic            dmem_rvalid_in,
  output logic            wr_en_out,
  output logic [RA_W-1:0] rd_addr_out,
  output logic [XLEN-1:0] rd_out,
  output logic            stall_out
);

  wb_state_t       state;
  logic [RA_W-1:0] ld_rd_p1;
  logic            ld_wr_p1;
  logic [1:0]      ld_size_p1;
  logic            ld_uns_p1;
  logic [1:0]      ld_off_p1;

  logic            accept;
  logic [XLEN-1:0] src_data;
  logic [XLEN-1:0] load_data;

  assign accept = valid_in && !stall_out;

  always_comb begin
    src_data = alu_result_in;
    case (wb_src_in)
      WB_CSR:  src_data = csr_data_in;
      WB_PC4:  src_data = pc_plus_4_in;
      default: src_data = alu_result_in;
    endcase
  end

  msrv32_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .data          (dmem_rdata_in),
    .offset        (ld_off_p1),
    .size          (ld_size_p1),
    .load_unsigned (ld_uns_p1),
    .result        (load_data)
  );

  // Stage boundary: execute -> register-file write port / load capture.
  // stall_out mirrors the state so it is high through the rvalid cycle; the
  // next instruction therefore lands one cycle after the load write.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state       <= ST_IDLE;
      stall_out   <= 1'b0;
      wr_en_out   <= 1'b0;
      rd_addr_out <= '0;
      rd_out      <= '0;
      ld_rd_p1    <= '0;
      ld_wr_p1    <= 1'b0;
      ld_size_p1  <= '0;
      ld_uns_p1   <= 1'b0;
      ld_off_p1   <= '0;
    end else begin
      wr_en_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (wb_src_in == WB_LOAD) begin
              state      <= ST_WAIT_LOAD;
              stall_out  <= 1'b1;
              ld_rd_p1   <= rd_addr_in;
              ld_wr_p1   <= rf_wr_en_in;
              ld_size_p1 <= load_size_in;
              ld_uns_p1  <= load_unsigned_in;
              ld_off_p1  <= alu_result_in[1:0];
            end else begin
              wr_en_out   <= rf_wr_en_in && (rd_addr_in != '0);
              rd_addr_out <= rd_addr_in;
              rd_out      <= src_data;
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (dmem_rvalid_in) begin
            state       <= ST_IDLE;
            stall_out   <= 1'b0;
            wr_en_out   <= ld_wr_p1 && (ld_rd_p1 != '0);
            rd_addr_out <= ld_rd_p1;
            rd_out      <= load_data;
          end
        end
        default: begin
          state     <= ST_IDLE;
          stall_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
